pspin_cmd_id_alloc: RTL and testbench

- Per-cluster allocator for HPU command identifiers.
- Generalises the fixed {cluster_id, core_id, local_cmd_id} command-ID scheme to a parametrised number of cores and slots per core.
- Adds round-robin grant arbitration, a runtime per-core in-flight cap, completion-driven slot release, per-core idle (fence) status and sticky error detection.
- Sits between the HPU command issue path and the command unit, and consumes command responses.

---
 rtl/pspin_cmd_id_alloc.sv | 172 +++++++++++++++++
 tb/tb_pspin_cmd_id_alloc.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pspin_cmd_id_alloc.sv
// pspin_cmd_id_alloc
//   Per-cluster allocator for HPU command identifiers. Each core owns NUM_CMDS
//   local command slots; a slot is marked busy when a command ID is granted and
//   cleared when the matching response comes back. Grants are arbitrated
//   round-robin across cores, one per cycle, under a runtime per-core cap.
//
// Ports
//   clk_i, rst_i      clock, asynchronous active-high reset
//   cluster_id_i      cluster field inserted into every issued ID
//   limit_i           per-core in-flight cap (0 or >= NUM_CMDS means NUM_CMDS)
//   alloc_req_i       per-core request, held by the requester until granted
//   alloc_gnt_o       one-hot grant (zero-latency, combinational)
//   alloc_valid_o     OR of alloc_gnt_o
//   alloc_id_o        {cluster, core, local} of the granted slot
//   resp_valid_i      completion strobe
//   resp_cmd_id_i     packed ID being released
//   inflight_o        per-core busy-slot count, core c at [c*(CMD_ID_W+1) +: CMD_ID_W+1]
//   core_idle_o       core has no busy slot
//   core_full_o       core is at its effective cap
//   err_o             sticky flag: a response named a slot that was not busy
module pspin_cmd_id_alloc #(
  parameter int NUM_CORES    = 8,
  parameter int NUM_CMDS     = 4,
  parameter int CLUSTER_ID_W = 2,
  parameter int CORE_ID_W    = $clog2(NUM_CORES),
  parameter int CMD_ID_W     = $clog2(NUM_CMDS),
  parameter int ID_W         = CLUSTER_ID_W + CORE_ID_W + CMD_ID_W
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [CLUSTER_ID_W-1:0]             cluster_id_i,
  input  logic [CMD_ID_W:0]                   limit_i,
  input  logic [NUM_CORES-1:0]                alloc_req_i,
  output logic [NUM_CORES-1:0]                alloc_gnt_o,
  output logic                                alloc_valid_o,
  output logic [ID_W-1:0]                     alloc_id_o,
  input  logic                                resp_valid_i,
  input  logic [ID_W-1:0]                     resp_cmd_id_i,
  output logic [NUM_CORES*(CMD_ID_W+1)-1:0]   inflight_o,
  output logic [NUM_CORES-1:0]                core_idle_o,
  output logic [NUM_CORES-1:0]                core_full_o,
  output logic                                err_o
);

  localparam int CNT_W = CMD_ID_W + 1;
  localparam logic [CNT_W-1:0] MAX_CAP = CNT_W'(NUM_CMDS);

  logic [NUM_CMDS-1:0]           busy_q    [NUM_CORES];
  logic [NUM_CMDS-1:0]           busy_next [NUM_CORES];
  logic [CORE_ID_W-1:0]          rr_q, rr_next;
  logic                          err_q, err_next;

  logic [CNT_W-1:0]              cap;
  logic [NUM_CORES*CNT_W-1:0]    count_flat;
  logic [NUM_CORES*CMD_ID_W-1:0] free_flat;
  logic [NUM_CORES-1:0]          eligible;

  logic                          found;
  logic                          grant;
  int                            idx;
  logic [CORE_ID_W-1:0]          gnt_core;
  logic [CMD_ID_W-1:0]           gnt_local;

  logic [CLUSTER_ID_W-1:0]       resp_cl;
  logic [CORE_ID_W-1:0]          resp_core;
  logic [CMD_ID_W-1:0]           resp_local;
  logic                          rel_hit;
  logic                          rel_legal;

  always_comb cap = (limit_i == '0 || limit_i >= MAX_CAP) ? MAX_CAP : limit_i;

  // Per-core occupancy, lowest free slot and status flags.
  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
    logic [CNT_W-1:0]    cnt;
    logic [CMD_ID_W-1:0] lfree;

    always_comb begin
      cnt = '0;
      for (int l = 0; l < NUM_CMDS; l++) cnt = cnt + CNT_W'(busy_q[gi][l]);
    end

    // Scan downwards so the last hit is the lowest free index.
    always_comb begin
      lfree = '0;
      for (int l = NUM_CMDS - 1; l >= 0; l--) begin
        if (!busy_q[gi][l]) lfree = CMD_ID_W'(l);
      end
    end

    assign count_flat[gi*CNT_W +: CNT_W]      = cnt;
    assign free_flat[gi*CMD_ID_W +: CMD_ID_W] = lfree;
    assign eligible[gi]    = alloc_req_i[gi] && (cnt < cap);
    assign core_idle_o[gi] = (cnt == '0);
    assign core_full_o[gi] = (cnt >= cap);
  end

  // Round-robin pick: first eligible core starting at rr_q.
  always_comb begin
    found    = 1'b0;
    gnt_core = '0;
    idx      = 0;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = (int'(rr_q) + k) % NUM_CORES;
      if (!found && eligible[idx]) begin
        found    = 1'b1;
        gnt_core = CORE_ID_W'(idx);
      end
    end
    gnt_local = free_flat[gnt_core*CMD_ID_W +: CMD_ID_W];
  end

  // Grants are suppressed while reset is held so no ID escapes that the
  // cleared bitmap would not remember.
  assign grant         = found && !rst_i;
  assign alloc_gnt_o   = grant ? (NUM_CORES'(1) << gnt_core) : '0;
  assign alloc_valid_o = |alloc_gnt_o;
  assign alloc_id_o    = grant ? {cluster_id_i, gnt_core, gnt_local} : '0;

  // Release decode. Matching by loop keeps every busy_q index in range even
  // when NUM_CORES or NUM_CMDS is not a power of two.
  assign {resp_cl, resp_core, resp_local} = resp_cmd_id_i;

  always_comb begin
    rel_hit = 1'b0;
    for (int c = 0; c < NUM_CORES; c++) begin
      for (int l = 0; l < NUM_CMDS; l++) begin
        if (resp_core == CORE_ID_W'(c) && resp_local == CMD_ID_W'(l) && busy_q[c][l])
          rel_hit = 1'b1;
      end
    end
  end

  assign rel_legal = resp_valid_i && (resp_cl == cluster_id_i) && rel_hit;

  // Release clears a busy slot and grant sets a free one, so both can land on
  // the same edge without colliding.
  always_comb begin
    for (int c = 0; c < NUM_CORES; c++) busy_next[c] = busy_q[c];
    rr_next  = rr_q;
    err_next = err_q;

    for (int c = 0; c < NUM_CORES; c++) begin
      for (int l = 0; l < NUM_CMDS; l++) begin
        if (rel_legal && resp_core == CORE_ID_W'(c) && resp_local == CMD_ID_W'(l))
          busy_next[c][l] = 1'b0;
      end
    end

    if (resp_valid_i && !rel_legal) err_next = 1'b1;

    if (grant) begin
      busy_next[gnt_core][gnt_local] = 1'b1;
      rr_next = (gnt_core == CORE_ID_W'(NUM_CORES - 1)) ? '0 : gnt_core + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < NUM_CORES; c++) busy_q[c] <= '0;
      rr_q  <= '0;
      err_q <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CORES; c++) busy_q[c] <= busy_next[c];
      rr_q  <= rr_next;
      err_q <= err_next;
    end
  end

  assign inflight_o = count_flat;
  assign err_o      = err_q;

endmodule

// File: tb/tb_pspin_cmd_id_alloc.sv
// Testbench for pspin_cmd_id_alloc (NUM_CORES=8, NUM_CMDS=4, CLUSTER_ID_W=2).
// Directed scenario tasks followed by a randomized run checked against a
// slot-bitmap reference model. Inputs change 1 time unit after the rising
// edge; outputs are sampled on the falling edge.
module tb_pspin_cmd_id_alloc;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cluster_id;
  logic [2:0]  limit;
  logic [7:0]  alloc_req;
  logic [7:0]  alloc_gnt;
  logic        alloc_valid;
  logic [6:0]  alloc_id;
  logic        resp_valid;
  logic [6:0]  resp_id;
  logic [23:0] inflight;
  logic [7:0]  core_idle;
  logic [7:0]  core_full;
  logic        err;

  int passed = 0;
  int total  = 0;

  // reference model state
  bit mbusy [8][4];
  int mrr;
  bit merr;

  always #5 clk = ~clk;

  pspin_cmd_id_alloc dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .cluster_id_i  (cluster_id),
    .limit_i       (limit),
    .alloc_req_i   (alloc_req),
    .alloc_gnt_o   (alloc_gnt),
    .alloc_valid_o (alloc_valid),
    .alloc_id_o    (alloc_id),
    .resp_valid_i  (resp_valid),
    .resp_cmd_id_i (resp_id),
    .inflight_o    (inflight),
    .core_idle_o   (core_idle),
    .core_full_o   (core_full),
    .err_o         (err)
  );

  function automatic logic [6:0] mkid(input int cl, input int c, input int l);
    logic [1:0] a;
    logic [2:0] b;
    logic [1:0] d;
    a = cl[1:0];
    b = c[2:0];
    d = l[1:0];
    return {a, b, d};
  endfunction

  function automatic logic [2:0] infl(input int c);
    return inflight[c*3 +: 3];
  endfunction

  function automatic int mcount(input int c);
    int n = 0;
    for (int l = 0; l < 4; l++) n += int'(mbusy[c][l]);
    return n;
  endfunction

  function automatic int mcap(input logic [2:0] lim);
    return (lim == 3'd0 || lim >= 3'd4) ? 4 : int'(lim);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    alloc_req = '0;
    resp_valid = 1'b0;
    limit = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic model_reset;
    for (int c = 0; c < 8; c++)
      for (int l = 0; l < 4; l++) mbusy[c][l] = 1'b0;
    mrr = 0;
    merr = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cluster_id = 2'd2;
    limit = '0;
    alloc_req = 8'hFF;
    resp_valid = 1'b0;
    resp_id = '0;
    #2;
    total++; if (alloc_gnt !== 8'h00) $display("FAIL reset_gnt: got %h want 00", alloc_gnt); else passed++;
    total++; if (alloc_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", alloc_valid); else passed++;
    total++; if (inflight !== 24'h0) $display("FAIL reset_inflight: got %h want 000000", inflight); else passed++;
    total++; if (core_idle !== 8'hFF) $display("FAIL reset_idle: got %h want ff", core_idle); else passed++;
    total++; if (core_full !== 8'h00) $display("FAIL reset_full: got %h want 00", core_full); else passed++;
    total++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else passed++;
    alloc_req = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single;
    do_reset();
    alloc_req = 8'h08;
    @(negedge clk);
    total++; if (alloc_gnt !== 8'h08) $display("FAIL single_gnt: got %h want 08", alloc_gnt); else passed++;
    total++; if (alloc_id !== mkid(2, 3, 0)) $display("FAIL single_id: got %h want %h", alloc_id, mkid(2, 3, 0)); else passed++;
    tick();
    alloc_req = '0;
    @(negedge clk);
    total++; if (infl(3) !== 3'd1) $display("FAIL single_inflight: got %0d want 1", infl(3)); else passed++;
    total++; if (core_idle[3] !== 1'b0) $display("FAIL single_idle: got %b want 0", core_idle[3]); else passed++;
    tick();
  endtask

  task automatic test_fill_release;
    do_reset();
    alloc_req = 8'h01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 4) begin
        total++;
        if (alloc_gnt !== 8'h01 || alloc_id !== mkid(2, 0, i))
          $display("FAIL fill_grant[%0d]: got gnt=%h id=%h want gnt=01 id=%h", i, alloc_gnt, alloc_id, mkid(2, 0, i));
        else passed++;
      end else begin
        total++; if (alloc_gnt !== 8'h00) $display("FAIL fill_nogrant: got %h want 00", alloc_gnt); else passed++;
        total++; if (core_full[0] !== 1'b1) $display("FAIL fill_full: got %b want 1", core_full[0]); else passed++;
      end
      tick();
    end
    alloc_req = '0;
    resp_valid = 1'b1;
    resp_id = mkid(2, 0, 1);
    tick();
    resp_valid = 1'b0;
    alloc_req = 8'h01;
    @(negedge clk);
    total++;
    if (alloc_gnt !== 8'h01 || alloc_id !== mkid(2, 0, 1))
      $display("FAIL fill_regrant: got gnt=%h id=%h want gnt=01 id=%h", alloc_gnt, alloc_id, mkid(2, 0, 1));
    else passed++;
    tick();
    alloc_req = '0;
  endtask

  task automatic test_rr_wrap;
    logic [7:0] want;
    do_reset();
    alloc_req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      want = '0;
      want[i % 8] = 1'b1;
      @(negedge clk);
      total++;
      if (alloc_gnt !== want || alloc_valid !== 1'b1)
        $display("FAIL rr_grant[%0d]: got gnt=%h valid=%b want gnt=%h valid=1", i, alloc_gnt, alloc_valid, want);
      else passed++;
      tick();
    end
    alloc_req = '0;
  endtask

  task automatic test_limit_lower;
    do_reset();
    limit = 3'd2;
    alloc_req = 8'h20;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (alloc_gnt !== ((i < 2) ? 8'h20 : 8'h00))
        $display("FAIL limit_fill[%0d]: got %h want %h", i, alloc_gnt, (i < 2) ? 8'h20 : 8'h00);
      else passed++;
      tick();
    end
    limit = 3'd1;
    @(negedge clk);
    total++; if (infl(5) !== 3'd2) $display("FAIL limit_norevoke: got %0d want 2", infl(5)); else passed++;
    total++; if (alloc_gnt !== 8'h00) $display("FAIL limit_block0: got %h want 00", alloc_gnt); else passed++;
    tick();
    resp_valid = 1'b1;
    resp_id = mkid(2, 5, 0);
    tick();
    resp_valid = 1'b0;
    @(negedge clk);
    total++; if (infl(5) !== 3'd1) $display("FAIL limit_rel1_count: got %0d want 1", infl(5)); else passed++;
    total++; if (alloc_gnt !== 8'h00) $display("FAIL limit_block1: got %h want 00", alloc_gnt); else passed++;
    tick();
    resp_valid = 1'b1;
    resp_id = mkid(2, 5, 1);
    tick();
    resp_valid = 1'b0;
    @(negedge clk);
    total++;
    if (alloc_gnt !== 8'h20 || alloc_id !== mkid(2, 5, 0))
      $display("FAIL limit_regrant: got gnt=%h id=%h want gnt=20 id=%h", alloc_gnt, alloc_id, mkid(2, 5, 0));
    else passed++;
    tick();
    alloc_req = '0;
    limit = '0;
  endtask

  task automatic test_illegal_release;
    do_reset();
    resp_valid = 1'b1;
    resp_id = mkid(2, 4, 0);
    @(negedge clk);
    total++; if (err !== 1'b0) $display("FAIL illegal_pre: got %b want 0", err); else passed++;
    tick();
    resp_valid = 1'b0;
    alloc_req = 8'h10;
    @(negedge clk);
    total++; if (err !== 1'b1) $display("FAIL illegal_notbusy: got %b want 1", err); else passed++;
    tick();
    alloc_req = '0;
    resp_valid = 1'b1;
    resp_id = mkid(1, 4, 0);
    tick();
    resp_valid = 1'b0;
    @(negedge clk);
    total++; if (infl(4) !== 3'd1) $display("FAIL illegal_cluster_kept: got %0d want 1", infl(4)); else passed++;
    total++; if (err !== 1'b1) $display("FAIL illegal_sticky: got %b want 1", err); else passed++;
    tick();
    tick();
    rst = 1'b1;
    #1;
    total++; if (err !== 1'b0) $display("FAIL illegal_rstclear: got %b want 0", err); else passed++;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_same_cycle;
    do_reset();
    alloc_req = 8'h02;
    for (int i = 0; i < 4; i++) tick();
    resp_valid = 1'b1;
    resp_id = mkid(2, 1, 2);
    @(negedge clk);
    total++; if (alloc_gnt !== 8'h00) $display("FAIL same_nogrant: got %h want 00", alloc_gnt); else passed++;
    tick();
    resp_valid = 1'b0;
    @(negedge clk);
    total++;
    if (alloc_gnt !== 8'h02 || alloc_id !== mkid(2, 1, 2))
      $display("FAIL same_regrant: got gnt=%h id=%h want gnt=02 id=%h", alloc_gnt, alloc_id, mkid(2, 1, 2));
    else passed++;
    tick();
    alloc_req = '0;
  endtask

  task automatic test_async_reset_mid;
    do_reset();
    alloc_req = 8'hFF;
    tick();
    tick();
    tick();
    #3;
    rst = 1'b1;
    #1;
    total++; if (alloc_gnt !== 8'h00) $display("FAIL async_gnt: got %h want 00", alloc_gnt); else passed++;
    total++; if (inflight !== 24'h0) $display("FAIL async_inflight: got %h want 000000", inflight); else passed++;
    alloc_req = '0;
    tick();
    rst = 1'b0;
    resp_valid = 1'b1;
    resp_id = mkid(2, 0, 0);
    tick();
    resp_valid = 1'b0;
    @(negedge clk);
    total++; if (err !== 1'b1) $display("FAIL async_forgotten: got %b want 1", err); else passed++;
    tick();
  endtask

  task automatic test_random(input int n);
    int gcore, gloc, cap, p, cl, c, l;
    int cand[$];
    logic [7:0]  exp_gnt, exp_idle, exp_full;
    logic [23:0] exp_infl;
    logic [6:0]  rid;
    do_reset();
    model_reset();
    for (int t = 0; t < n; t++) begin
      alloc_req = 8'($urandom);
      limit = 3'($urandom_range(0, 7));
      resp_valid = ($urandom_range(0, 1) == 1);
      cand.delete();
      for (int ci = 0; ci < 8; ci++)
        for (int li = 0; li < 4; li++)
          if (mbusy[ci][li]) cand.push_back(ci * 4 + li);
      if (cand.size() > 0 && $urandom_range(0, 9) != 0) begin
        p = cand[$urandom_range(0, cand.size() - 1)];
        rid = mkid(2, p / 4, p % 4);
      end else begin
        rid = 7'($urandom);
      end
      resp_id = rid;

      cap = mcap(limit);
      gcore = -1;
      for (int k = 0; k < 8; k++) begin
        c = (mrr + k) % 8;
        if (gcore < 0 && alloc_req[c] && mcount(c) < cap) gcore = c;
      end
      gloc = -1;
      exp_gnt = '0;
      if (gcore >= 0) begin
        exp_gnt[gcore] = 1'b1;
        for (int li = 3; li >= 0; li--) if (!mbusy[gcore][li]) gloc = li;
      end
      for (int ci = 0; ci < 8; ci++) begin
        exp_infl[ci*3 +: 3] = 3'(mcount(ci));
        exp_idle[ci] = (mcount(ci) == 0);
        exp_full[ci] = (mcount(ci) >= cap);
      end

      @(negedge clk);
      total++; if (alloc_gnt !== exp_gnt) $display("FAIL rand_gnt t=%0d: got %h want %h", t, alloc_gnt, exp_gnt); else passed++;
      total++; if (alloc_valid !== (gcore >= 0)) $display("FAIL rand_valid t=%0d: got %b want %b", t, alloc_valid, gcore >= 0); else passed++;
      if (gcore >= 0) begin
        total++;
        if (alloc_id !== mkid(2, gcore, gloc)) $display("FAIL rand_id t=%0d: got %h want %h", t, alloc_id, mkid(2, gcore, gloc));
        else passed++;
      end
      total++; if (inflight !== exp_infl) $display("FAIL rand_inflight t=%0d: got %h want %h", t, inflight, exp_infl); else passed++;
      total++; if (core_idle !== exp_idle) $display("FAIL rand_idle t=%0d: got %h want %h", t, core_idle, exp_idle); else passed++;
      total++; if (core_full !== exp_full) $display("FAIL rand_full t=%0d: got %h want %h", t, core_full, exp_full); else passed++;
      total++; if (err !== merr) $display("FAIL rand_err t=%0d: got %b want %b", t, err, merr); else passed++;
      tick();

      if (resp_valid) begin
        cl = int'(rid[6:5]);
        c  = int'(rid[4:2]);
        l  = int'(rid[1:0]);
        if (cl == 2 && mbusy[c][l]) mbusy[c][l] = 1'b0;
        else merr = 1'b1;
      end
      if (gcore >= 0) begin
        mbusy[gcore][gloc] = 1'b1;
        mrr = (gcore + 1) % 8;
      end
    end
    resp_valid = 1'b0;
    alloc_req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_release();
    test_rr_wrap();
    test_limit_lower();
    test_illegal_release();
    test_same_cycle();
    test_async_reset_mid();
    test_random(600);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
